exposure_controller: RTL

//  Camera main-FSM initiator. Sequences IDLE -> EXPOSURE -> READOUT -> IDLE.

---
 rtl/exposure_pkg.sv | 24 ++
 rtl/exp_time_register.sv | 52 +++++
 rtl/exposure_controller.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/exposure_pkg.sv
// ---------------------------------------------------------------------------
// exposure_pkg
//   State encodings for the camera main FSM and the readout sub-FSM.
//   The readout encodings match the Timer_Counter that reports its state
//   on i_RD_FSM. Only s_END matters here, but the full table is kept so
//   both sides of the handshake share one definition.
// ---------------------------------------------------------------------------
package exposure_pkg;

   // Main FSM, driven out on o_Main_FSM (2'b11 is never produced)
   localparam logic [1:0] s_IDLE     = 2'b00;
   localparam logic [1:0] s_EXPOSURE = 2'b01;
   localparam logic [1:0] s_READOUT  = 2'b10;

   // Readout sub-FSM, as reported by Timer_Counter
   localparam logic [2:0] s_INIT = 3'b000;
   localparam logic [2:0] s_RD_1 = 3'b001;
   localparam logic [2:0] s_RD_2 = 3'b010;
   localparam logic [2:0] s_RD_3 = 3'b011;
   localparam logic [2:0] s_RD_4 = 3'b100;
   localparam logic [2:0] s_RD_5 = 3'b101;
   localparam logic [2:0] s_END  = 3'b110;

endpackage

// File: rtl/exp_time_register.sv
// ---------------------------------------------------------------------------
// exp_time_register
//   Saturating up/down register that holds the user exposure time.
//   Ports:
//     clk    in   system clock
//     srst   in   synchronous active-high reset (loads DEFAULT_VAL)
//     hold   in   freeze the value regardless of inc/dec
//     inc    in   +1 per cycle, saturating at MAX_VAL
//     dec    in   -1 per cycle, saturating at MIN_VAL
//     value  out  current setting (registered)
//   inc and dec both high leaves the value unchanged.
// ---------------------------------------------------------------------------
module exp_time_register #(
   parameter int W           = 5,
   parameter int MIN_VAL     = 2,
   parameter int MAX_VAL     = 30,
   parameter int DEFAULT_VAL = 2
) (
   input  logic         clk,
   input  logic         srst,
   input  logic         hold,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] value
);

   localparam logic [W-1:0] MIN_V = W'(MIN_VAL);
   localparam logic [W-1:0] MAX_V = W'(MAX_VAL);
   localparam logic [W-1:0] DEF_V = W'(DEFAULT_VAL);

   logic [W-1:0] value_reg;
   logic [W-1:0] value_next;

   always_comb begin
      value_next = value_reg;
      if (!hold) begin
         if (inc && !dec) begin
            if (value_reg < MAX_V) value_next = value_reg + 1'b1;
         end else if (dec && !inc) begin
            if (value_reg > MIN_V) value_next = value_reg - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (srst) value_reg <= DEF_V;
      else      value_reg <= value_next;
   end

   assign value = value_reg;

endmodule

// File: rtl/exposure_controller.sv
// ---------------------------------------------------------------------------
// exposure_controller
//   Camera main FSM: IDLE -> EXPOSURE -> READOUT -> IDLE.
//   Ports:
//     i_Clock         in   system clock
//     i_Reset         in   synchronous active-high reset
//     i_Init          in   start one exposure+readout frame (sampled in IDLE)
//     i_Exp_increase  in   +1 exposure time per cycle (IDLE only)
//     i_Exp_decrease  in   -1 exposure time per cycle (IDLE only)
//     i_RD_FSM        in   readout sub-FSM state from Timer_Counter
//     o_Main_FSM      out  main FSM state
//     o_Erase         out  high in IDLE
//     o_Expose        out  high in EXPOSURE
//     o_Exp_time      out  current exposure setting
//     o_Done          out  1-cycle pulse on READOUT->IDLE
//     o_Error         out  1-cycle readout watchdog pulse
//   Build option: define RD_TIMEOUT_EN to enable the readout watchdog
//   (RD_TIMEOUT cycles). Without it READOUT waits for s_END forever and
//   o_Error stays 0.
//   All outputs are registered; flags are computed from the next state.
// ---------------------------------------------------------------------------
module exposure_controller
   import exposure_pkg::*;
#(
   parameter int EXP_W       = 5,
   parameter int EXP_MIN     = 2,
   parameter int EXP_MAX     = 30,
   parameter int EXP_DEFAULT = 2
`ifdef RD_TIMEOUT_EN
   ,
   parameter int RD_TIMEOUT  = 64
`endif
) (
   input  logic             i_Clock,
   input  logic             i_Reset,
   input  logic             i_Init,
   input  logic             i_Exp_increase,
   input  logic             i_Exp_decrease,
   input  logic [2:0]       i_RD_FSM,
   output logic [1:0]       o_Main_FSM,
   output logic             o_Erase,
   output logic             o_Expose,
   output logic [EXP_W-1:0] o_Exp_time,
   output logic             o_Done,
   output logic             o_Error
);

   logic [1:0]       state_reg, state_next;
   logic [EXP_W-1:0] cnt_reg, cnt_next;
   logic             armed_reg, armed_next;
   logic             erase_reg, expose_reg;
   logic             done_reg, done_next;
   logic             error_reg, error_next;
   logic [EXP_W-1:0] exp_time;
   logic             exp_hold;

`ifdef RD_TIMEOUT_EN
   localparam int             WD_W    = $clog2(RD_TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(RD_TIMEOUT - 1);
   logic [WD_W-1:0] wd_reg, wd_next;
`endif

   // Exposure time may only change while idle and not launching a frame,
   // so the value copied into the down-counter is the one the user sees.
   assign exp_hold = (state_reg != s_IDLE) || i_Init;

   exp_time_register #(
      .W           (EXP_W),
      .MIN_VAL     (EXP_MIN),
      .MAX_VAL     (EXP_MAX),
      .DEFAULT_VAL (EXP_DEFAULT)
   ) u_exp_time (
      .clk   (i_Clock),
      .srst  (i_Reset),
      .hold  (exp_hold),
      .inc   (i_Exp_increase),
      .dec   (i_Exp_decrease),
      .value (exp_time)
   );

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      armed_next = armed_reg;
      done_next  = 1'b0;
      error_next = 1'b0;
`ifdef RD_TIMEOUT_EN
      wd_next    = '0;
`endif
      case (state_reg)
         s_IDLE: begin
            if (i_Init) begin
               state_next = s_EXPOSURE;
               cnt_next   = exp_time;
            end
         end
         s_EXPOSURE: begin
            // Counter holds remaining cycles including the current one
            cnt_next = cnt_reg - 1'b1;
            if (cnt_reg == EXP_W'(1)) state_next = s_READOUT;
         end
         s_READOUT: begin
            // A leftover s_END from the previous frame must not end this one:
            // readout only completes after the sub-FSM has left s_END once.
            if (armed_reg && (i_RD_FSM == s_END)) begin
               state_next = s_IDLE;
               done_next  = 1'b1;
               armed_next = 1'b0;
            end
`ifdef RD_TIMEOUT_EN
            else if (wd_reg == WD_LAST) begin
               state_next = s_IDLE;
               error_next = 1'b1;
               armed_next = 1'b0;
            end
`endif
            else begin
               if (i_RD_FSM != s_END) armed_next = 1'b1;
`ifdef RD_TIMEOUT_EN
               wd_next = wd_reg + 1'b1;
`endif
            end
         end
         default: state_next = s_IDLE;
      endcase
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_reg  <= s_IDLE;
         cnt_reg    <= '0;
         armed_reg  <= 1'b0;
         erase_reg  <= 1'b1;
         expose_reg <= 1'b0;
         done_reg   <= 1'b0;
         error_reg  <= 1'b0;
`ifdef RD_TIMEOUT_EN
         wd_reg     <= '0;
`endif
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         armed_reg  <= armed_next;
         erase_reg  <= (state_next == s_IDLE);
         expose_reg <= (state_next == s_EXPOSURE);
         done_reg   <= done_next;
         error_reg  <= error_next;
`ifdef RD_TIMEOUT_EN
         wd_reg     <= wd_next;
`endif
      end
   end

   assign o_Main_FSM = state_reg;
   assign o_Erase    = erase_reg;
   assign o_Expose   = expose_reg;
   assign o_Exp_time = exp_time;
   assign o_Done     = done_reg;
   assign o_Error    = error_reg;

endmodule
